// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_cmd_pkg: shared types and constants for the UART command framer.  Rev 1.0
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OP   = 3'd1,
    ADDR = 3'd2,
    DHI  = 3'd3,
    DLO  = 3'd4,
    CHK  = 3'd5,
    HOLD = 3'd6
  } state_t;

  localparam int         FRAME_BYTES       = 6;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // One UART character is 10 bit times (start + 8 data + stop).
  function automatic int timeout_limit(input int clk_freq, input int baud_rate,
                                       input int timeout_bytes);
    return timeout_bytes * 10 * (clk_freq / baud_rate);
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_gap_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// byte_gap_timer: counts idle cycles between bytes, strobes at LIMIT.  Rev 1.0
// ---------------------------------------------------------------------------
module byte_gap_timer #(
  parameter int LIMIT = 156240
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // Strobes on the cycle whose edge would bring the count to LIMIT; a clear wins.
  assign expired = enable && !clear && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != W'(LIMIT))) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_cmd_ctrl: frames 6-byte UART commands and hands them off via valid/ready.  Rev 1.0
// ---------------------------------------------------------------------------
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int         CLK_FREQ      = 50000000,
  parameter int         BAUD_RATE     = 9600,
  parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_BYTES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  cmd_op,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_wdata,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        busy,
  output logic        err_chk,
  output logic        err_timeout,
  output logic        err_overrun
);

  localparam int LIMIT = timeout_limit(CLK_FREQ, BAUD_RATE, TIMEOUT_BYTES);

  state_t     state;
  logic [7:0] op_q, addr_q, dhi_q, dlo_q;
  logic [7:0] chk_calc;
  logic       timer_enable, timer_clear, expired;

  assign timer_enable = (state != IDLE) && (state != HOLD);
  assign timer_clear  = rx_valid || !timer_enable;
  assign chk_calc     = op_q ^ addr_q ^ dhi_q ^ dlo_q;

  byte_gap_timer #(
    .LIMIT(LIMIT)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      dhi_q       <= '0;
      dlo_q       <= '0;
      cmd_op      <= '0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      cmd_valid   <= 1'b0;
      busy        <= 1'b0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state <= OP;
            busy  <= 1'b1;
          end
        end
        // Body bytes are data even if they match the sync marker.
        OP, ADDR, DHI, DLO: begin
          if (rx_valid) begin
            case (state)
              OP:      op_q   <= rx_data;
              ADDR:    addr_q <= rx_data;
              DHI:     dhi_q  <= rx_data;
              default: dlo_q  <= rx_data;
            endcase
            state <= state_t'(state + 3'd1);
          end else if (expired) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end
        CHK: begin
          if (rx_valid) begin
            if (rx_data == chk_calc) begin
              cmd_op    <= op_q;
              cmd_addr  <= addr_q;
              cmd_wdata <= {dhi_q, dlo_q};
              cmd_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              err_chk <= 1'b1;
              state   <= IDLE;
              busy    <= 1'b0;
            end
          end else if (expired) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end
        HOLD: begin
          err_overrun <= rx_valid;
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_cmd_ctrl: directed, table-driven bench for the UART command framer.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

  // 96 kHz clock at 9600 baud: 10 cycles/bit, so the gap limit is 3*10*10 = 300.
  localparam int TB_LIMIT = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        busy;
  logic        err_chk;
  logic        err_timeout;
  logic        err_overrun;

  uart_cmd_ctrl #(
    .CLK_FREQ     (96000),
    .BAUD_RATE    (9600),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_BYTES(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .busy       (busy),
    .err_chk    (err_chk),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] bytes;   // first byte in the top octet
    logic [3:0]  len;
    logic        ev;      // a command is expected
    logic [7:0]  op;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic        echk;    // a checksum error is expected
  } vec_t;

  vec_t vt [5];

  int n_cmp = 0;
  int n_fail = 0;
  int n_valid, n_chk, n_to, n_over, n_unstable;
  logic [7:0]  cap_op, cap_addr;
  logic [15:0] cap_wd;
  logic        prev_valid;
  logic [31:0] prev_bus;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    n_valid = 0; n_chk = 0; n_to = 0; n_over = 0; n_unstable = 0;
    cap_op = '0; cap_addr = '0; cap_wd = '0;
  endtask

  // Advance one clock and sample outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (cmd_valid) begin
      n_valid++;
      cap_op   = cmd_op;
      cap_addr = cmd_addr;
      cap_wd   = cmd_wdata;
    end
    if (cmd_valid && prev_valid && ({cmd_op, cmd_addr, cmd_wdata} != prev_bus)) n_unstable++;
    prev_valid = cmd_valid;
    prev_bus   = {cmd_op, cmd_addr, cmd_wdata};
    n_chk  += int'(err_chk);
    n_to   += int'(err_timeout);
    n_over += int'(err_overrun);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_frame(input logic [63:0] bytes, input int len);
    for (int j = 0; j < len; j++) send_byte(bytes[63-8*j -: 8]);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; cmd_ready = 1'b0;
    prev_valid = 1'b0; prev_bus = '0;
    clr_mon();

    vt[0] = '{64'hA5011012_34370000, 4'd6, 1'b1, 8'h01, 8'h10, 16'h1234, 1'b0};
    vt[1] = '{64'hA5011012_34360000, 4'd6, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b1};
    vt[2] = '{64'hA5020000_01030000, 4'd6, 1'b1, 8'h02, 8'h00, 16'h0001, 1'b0};
    vt[3] = '{64'h00FFA5A5_A5000000, 4'd8, 1'b1, 8'hA5, 8'hA5, 16'h0000, 1'b0};
    vt[4] = '{64'hA57EA55A_0F8E0000, 4'd6, 1'b1, 8'h7E, 8'hA5, 16'h5A0F, 1'b0};

    repeat (3) tick();
    check("reset_outputs", {cmd_op, cmd_addr, cmd_wdata, cmd_valid, busy,
                            err_chk, err_timeout, err_overrun}, 64'h0);
    rst_n = 1'b1;
    tick();

    // Table-driven frames with the consumer always ready.
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clr_mon();
      send_frame(vt[i].bytes, int'(vt[i].len));
      repeat (6) tick();
      check($sformatf("v%0d_valid_cycles", i), n_valid, {63'h0, vt[i].ev});
      check($sformatf("v%0d_err_chk", i), n_chk, {63'h0, vt[i].echk});
      check($sformatf("v%0d_err_other", i), n_to + n_over, 0);
      check($sformatf("v%0d_busy_idle", i), busy, 0);
      if (vt[i].ev) begin
        check($sformatf("v%0d_op", i), cap_op, vt[i].op);
        check($sformatf("v%0d_addr", i), cap_addr, vt[i].addr);
        check($sformatf("v%0d_wdata", i), cap_wd, vt[i].wd);
      end
    end

    // Timeout: exactly TB_LIMIT idle cycles after a body byte.
    clr_mon();
    send_byte(8'hA5);
    rx_data = 8'h01; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    repeat (TB_LIMIT - 1) tick();
    check("to_not_early", n_to, 0);
    tick();
    check("to_pulse", n_to, 1);
    check("to_busy_low", busy, 0);
    repeat (5) tick();
    check("to_single_cycle", n_to, 1);
    clr_mon();
    send_frame(vt[0].bytes, 6);
    repeat (6) tick();
    check("to_recover_valid", n_valid, 1);
    check("to_recover_op", cap_op, 8'h01);

    // Gap one short of the limit: the byte lands on the expiry cycle and wins.
    clr_mon();
    send_byte(8'hA5);
    rx_data = 8'h01; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    repeat (TB_LIMIT - 1) tick();
    rx_data = 8'h10; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h37);
    repeat (6) tick();
    check("gap_short_no_to", n_to, 0);
    check("gap_short_valid", n_valid, 1);
    check("gap_short_wdata", cap_wd, 16'h1234);

    // Backpressure with an overrun byte during HOLD.
    clr_mon();
    cmd_ready = 1'b0;
    send_frame(64'hA50320AB_CD450000, 6);
    check("hold_valid", cmd_valid, 1);
    check("hold_busy", busy, 1);
    send_byte(8'h55);
    repeat (100) tick();
    check("hold_still_valid", cmd_valid, 1);
    check("hold_overrun", n_over, 1);
    check("hold_bus", {cmd_op, cmd_addr, cmd_wdata}, 64'h0320ABCD);
    cmd_ready = 1'b1;
    tick();
    check("hold_drop_after_accept", cmd_valid, 0);
    check("hold_busy_low", busy, 0);
    check("hold_stable", n_unstable, 0);

    // Accept and a sync byte arrive together in HOLD: accept, flag, discard.
    clr_mon();
    cmd_ready = 1'b0;
    send_frame(vt[2].bytes, 6);
    cmd_ready = 1'b1; rx_data = 8'hA5; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("coinc_accept", cmd_valid, 0);
    repeat (5) tick();
    check("coinc_overrun", n_over, 1);
    check("coinc_sync_discarded", busy, 0);

    // Asynchronous reset in the middle of a frame.
    clr_mon();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    check("rst_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_immediate", {cmd_op, cmd_addr, cmd_wdata, cmd_valid, busy,
                            err_chk, err_timeout, err_overrun}, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    clr_mon();
    send_frame(vt[0].bytes, 6);
    repeat (6) tick();
    check("rst_after_valid", n_valid, 1);
    check("rst_after_bus", {cap_op, cap_addr, cap_wd}, 64'h01101234);
    check("rst_after_errs", n_chk + n_to + n_over, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
